// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared constants for the nibble-serial 16-bit add/subtract
//                unit: datapath width, nibble count and FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Counter value of the most significant nibble; EXEC ends after it.
  localparam logic [1:0] CNT_LAST = 2'(NIBBLES - 1);

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/nibble_add4.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_add4
//  Description : Purely combinational 4-bit adder, sum = a + b + cin.
//  Ports       : a[3:0], b[3:0], cin  -> operands and carry-in
//                sum[3:0], cout       -> 4-bit sum and carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
  assign sum    = w_full[3:0];
  assign cout   = w_full[4];

endmodule : nibble_add4
`default_nettype wire

// File: rtl/addsub16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : addsub16_seq
//  Description : Sequential 16-bit two's-complement add/subtract. One nibble
//                is processed per cycle, LSB first, through a single shared
//                4-bit adder. Result and flags hold until the next start.
//  Ports       : clk, rst (sync, active-high)
//                start, sub, a[15:0], b[15:0]   -> request and operands
//                busy, done                     -> status / one-cycle pulse
//                result[15:0], carry, zero, overflow -> outputs, held
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub16_seq
  import addsub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  state_t           state_q,    state_d;
  logic [1:0]       cnt_q,      cnt_d;
  logic             cin_q,      cin_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic             sub_q,      sub_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             carry_q,    carry_d;
  logic             zero_q,     zero_d;
  logic             overflow_q, overflow_d;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_sum;
  logic       nib_cout;
  logic [3:0] nib_idx;

  // Bit offset of the current nibble.
  assign nib_idx = {cnt_q, 2'b00};
  assign nib_a   = a_q[nib_idx +: 4];
  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign nib_b   = b_q[nib_idx +: 4] ^ {4{sub_q}};

  nibble_add4 u_nibble_add4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cin_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      cin_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cin_q      <= cin_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EXEC;
      ST_EXEC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d      = cnt_q;
    cin_d      = cin_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    if (state_q == ST_IDLE && start) begin
      a_d        = a;
      b_d        = b;
      sub_d      = sub;
      cnt_d      = 2'd0;
      cin_d      = sub;
      result_d   = '0;
      carry_d    = 1'b0;
      zero_d     = 1'b0;
      overflow_d = 1'b0;
    end else if (state_q == ST_EXEC) begin
      result_d[nib_idx +: 4] = nib_sum;
      cin_d = nib_cout;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == CNT_LAST) begin
        // Flags are formed from the top nibble directly, since result_q
        // does not yet hold it on this edge.
        carry_d    = nib_cout;
        zero_d     = ({nib_sum, result_q[WIDTH-5:0]} == '0);
        overflow_d = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                     (nib_sum[3] != a_q[WIDTH-1]);
      end
    end
  end

  // Outputs.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    result   = result_q;
    carry    = carry_q;
    zero     = zero_q;
    overflow = overflow_q;
  end

endmodule : addsub16_seq
`default_nettype wire
